fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the program counter register and sequences it against a request/grant/response instruction-memory port.
- Presents each fetched instruction to the decode/execute stage with a valid/stall handshake.
- Applies the branch/jump redirect (PCSrc, PCTarget) at the moment the held instruction is consumed.
- Sits between instruction memory and the core datapath, replacing a free-running PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- MAX_WAIT, 15, maximum cycles allowed in WAIT without imem_rvalid before a timeout error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- PCTarget  input  32  redirect target address.
- PCSrc  input  1  redirect select: 1 = next PC is PCTarget, 0 = PC+4.
- stall  input  1  consumer not accepting the presented instruction.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr  output  32  held instruction.
- instr_valid  output  1  instr/instr_pc valid.
- instr_pc  output  32  address of the held instruction.
- program_counter  output  32  current fetch PC.
- fetch_err  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, async): state=IDLE, program_counter=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, wait counter=0. Reset asserted mid-operation aborts any outstanding request; a late imem_rvalid after release is ignored unless in WAIT.
- All outputs are registered except imem_req and imem_addr, which are Moore decodes of state.
- IDLE: one cycle after reset deasserts, go to REQ.
- REQ: imem_req=1, imem_addr=program_counter. The address holds stable until grant. imem_gnt=1 -> WAIT with wait counter cleared. Otherwise stay in REQ.
- WAIT: imem_req=0; the wait counter increments each cycle.
  - imem_rvalid=1 -> instr<=imem_rdata, instr_pc<=program_counter, instr_valid<=1, go to HOLD.
  - Counter reaches MAX_WAIT with no rvalid -> ERR.
  - rvalid and gnt arriving in the same cycle is not possible (gnt is only sampled in REQ).
- HOLD: instr_valid=1, instr and instr_pc held stable.
  - stall=1: stay in HOLD; PCSrc is ignored.
  - stall=0: the instruction is consumed. Next cycle: instr_valid=0 and program_counter <= PCSrc ? PCTarget : program_counter+4, then go to REQ.
  - PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - stall=0, PCSrc=1 with PCTarget[1:0]!=0: go to ERR and leave program_counter unchanged.
- ERR: fetch_err=1 (sticky), imem_req=0, instr_valid=0; exit only via reset.
- Throughput: a grant in REQ plus rvalid on the first WAIT cycle gives one instruction per 3 cycles (REQ, WAIT, HOLD) with stall=0.
- The redirect has no extra latency: the first request after a taken redirect targets PCTarget.

Test Plan:
- Reset release, RESET_PC=0, gnt and rvalid immediate, stall=0, PCSrc=0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses with instr_pc 0x0, 0x4, 0x8; each instruction is 3 cycles apart.
- In HOLD with instr_pc=0x4, stall=0, PCSrc=1, PCTarget=0x0000_000A... misaligned -> fetch_err=1, imem_req stays 0. Repeat with PCTarget=0x0000_0040 -> next imem_addr=0x40, then 0x44.
- stall=1 held for 5 cycles in HOLD with PCSrc toggling -> instr and instr_pc unchanged, no new imem_req. Release stall with PCSrc=0 -> next imem_addr=instr_pc+4.
- imem_gnt withheld 4 cycles -> imem_req=1 and imem_addr stable for all 4 cycles; grant on cycle 5 -> WAIT.
- No rvalid for MAX_WAIT cycles -> fetch_err=1. Then assert reset=0 mid-ERR -> all outputs return to reset values and fetching restarts at RESET_PC.
- program_counter=0xFFFF_FFFC, consume with PCSrc=0 -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences a req/gnt/rvalid
// instruction-memory port and presents one held instruction at a time to
// the decode stage, applying branch/jump redirects when it is consumed.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCTarget,
    input  logic        PCSrc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] program_counter,
    output logic        fetch_err
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StErr
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_next;
    logic [CntW-1:0]   r_wait_cnt;
    logic [CntW-1:0]   w_wait_cnt_next;
    logic [CntW-1:0]   w_wait_cnt_inc;
    logic [31:0]       r_instr;
    logic [31:0]       w_instr_next;
    logic [31:0]       r_instr_pc;
    logic [31:0]       w_instr_pc_next;
    logic              r_instr_valid;
    logic              w_instr_valid_next;
    logic              r_fetch_err;
    logic              w_fetch_err_next;
    logic [31:0]       w_redirect_pc;
    logic              w_target_misaligned;

    assign w_wait_cnt_inc      = r_wait_cnt + 1'b1;
    assign w_redirect_pc       = PCSrc ? PCTarget : (r_pc + 32'd4);
    assign w_target_misaligned = PCSrc && (PCTarget[1:0] != 2'b00);

    // State and datapath registers; reset aborts any outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_wait_cnt    <= '0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_fetch_err   <= w_fetch_err_next;
        end
    end

    // Next-state and next-register decode for the fetch FSM.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_wait_cnt_next    = r_wait_cnt;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_fetch_err_next   = r_fetch_err;

        case (r_state)
            StIdle: begin
                w_state_next = StReq;
            end
            StReq: begin
                if (imem_gnt) begin
                    w_state_next    = StWait;
                    w_wait_cnt_next = '0;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    w_instr_next       = imem_rdata;
                    w_instr_pc_next    = r_pc;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = StHold;
                end else if (w_wait_cnt_inc == CntW'(MAX_WAIT)) begin
                    w_wait_cnt_next  = w_wait_cnt_inc;
                    w_fetch_err_next = 1'b1;
                    w_state_next     = StErr;
                end else begin
                    w_wait_cnt_next = w_wait_cnt_inc;
                end
            end
            StHold: begin
                // Redirect is only honoured on the consuming cycle.
                if (!stall) begin
                    w_instr_valid_next = 1'b0;
                    if (w_target_misaligned) begin
                        w_fetch_err_next = 1'b1;
                        w_state_next     = StErr;
                    end else begin
                        w_pc_next    = w_redirect_pc;
                        w_state_next = StReq;
                    end
                end
            end
            StErr: begin
                w_instr_valid_next = 1'b0;
                w_fetch_err_next   = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Request port is a pure decode of state.
    always_comb begin
        imem_req  = (r_state == StReq);
        imem_addr = (r_state == StReq) ? r_pc : 32'h0;
    end

    assign instr           = r_instr;
    assign instr_pc        = r_instr_pc;
    assign instr_valid     = r_instr_valid;
    assign program_counter = r_pc;
    assign fetch_err       = r_fetch_err;

endmodule
